// File: rtl/mem_bank_pkg.sv
// Shared types and helpers for the mem_bank_mp memory bank.
package mem_bank_pkg;

  localparam int unsigned BYTE_WIDTH = 8;
  // Helpers work on a fixed maximum width; callers zero-extend and truncate.
  localparam int unsigned MAX_DW = 256;
  localparam int unsigned MAX_NB = MAX_DW / BYTE_WIDTH;

  typedef enum logic {StInit, StReady} state_e;

  // Even parity per byte: byte plus its parity bit always holds an even number of ones.
  function automatic logic [MAX_NB-1:0] byte_parity(input logic [MAX_DW-1:0] word);
    logic [MAX_NB-1:0] par;
    for (int k = 0; k < MAX_NB; k++) begin
      par[k] = ^word[k*BYTE_WIDTH +: BYTE_WIDTH];
    end
    return par;
  endfunction

  function automatic logic [MAX_DW-1:0] byte_merge(input logic [MAX_DW-1:0] old_word,
                                                   input logic [MAX_DW-1:0] new_word,
                                                   input logic [MAX_NB-1:0] be);
    logic [MAX_DW-1:0] res;
    res = old_word;
    for (int k = 0; k < MAX_NB; k++) begin
      if (be[k]) res[k*BYTE_WIDTH +: BYTE_WIDTH] = new_word[k*BYTE_WIDTH +: BYTE_WIDTH];
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_bank_mp_if.sv
// Bus bundle for mem_bank_mp; carries wr_par_flip/parity_err when MEM_PARITY_EN is defined.
interface mem_bank_mp_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned NUM_RD     = 2
);

  logic                           init_busy;
  logic                           wr_en;
  logic [ADDR_WIDTH-1:0]          wr_address;
  logic [DATA_WIDTH/8-1:0]        wr_be;
  logic [DATA_WIDTH-1:0]          data_in;
  logic [NUM_RD-1:0]              rd_en;
  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_address;
  logic [NUM_RD*DATA_WIDTH-1:0]   data_out;
  logic [NUM_RD-1:0]              rd_valid;
`ifdef MEM_PARITY_EN
  logic                           wr_par_flip;
  logic [NUM_RD-1:0]              parity_err;
`endif

  modport master (
`ifdef MEM_PARITY_EN
    output wr_par_flip,
    input  parity_err,
`endif
    input  init_busy, data_out, rd_valid,
    output wr_en, wr_address, wr_be, data_in, rd_en, rd_address
  );

  modport slave (
`ifdef MEM_PARITY_EN
    input  wr_par_flip,
    output parity_err,
`endif
    output init_busy, data_out, rd_valid,
    input  wr_en, wr_address, wr_be, data_in, rd_en, rd_address
  );

endinterface

// File: rtl/mem_rd_port.sv
// One read port: range check, write-first forwarding, latency pipeline and
// (with MEM_PARITY_EN) parity check.
module mem_rd_port
  import mem_bank_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned MEM_SIZE   = 64,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           ready,
  input  logic                           rd_en,
  input  logic [ADDR_WIDTH-1:0]          rd_address,
  input  logic [DATA_WIDTH-1:0]          mem_word,
  input  logic                           wr_fire,
  input  logic [ADDR_WIDTH-1:0]          wr_address,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
`ifdef MEM_PARITY_EN
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] mem_par,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_par,
  output logic                           parity_err,
`endif
  output logic [DATA_WIDTH-1:0]          data_out,
  output logic                           rd_valid
);

  localparam int unsigned NB = DATA_WIDTH / BYTE_WIDTH;

  logic                  in_range;
  logic                  hit;
  logic                  req;
  logic [DATA_WIDTH-1:0] word;
  logic [DATA_WIDTH-1:0] data1_q;
  logic                  valid1_q;

  assign in_range = {1'b0, rd_address} < (ADDR_WIDTH+1)'(MEM_SIZE);
  assign hit      = wr_fire && (wr_address == rd_address);
  assign req      = ready && rd_en;

  always_comb begin
    word = '0;
    if (in_range) begin
      word = hit ? DATA_WIDTH'(byte_merge(MAX_DW'(mem_word), MAX_DW'(wr_data), MAX_NB'(wr_be)))
                 : mem_word;
    end
  end

`ifdef MEM_PARITY_EN
  logic [NB-1:0] par;
  logic          err;
  logic          err1_q;

  always_comb begin
    par = '0;
    if (in_range) par = hit ? ((mem_par & ~wr_be) | (wr_par & wr_be)) : mem_par;
  end
  assign err = |(NB'(byte_parity(MAX_DW'(word))) ^ par);
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      data1_q  <= '0;
      valid1_q <= 1'b0;
`ifdef MEM_PARITY_EN
      err1_q   <= 1'b0;
`endif
    end else begin
      valid1_q <= req;
      if (req) data1_q <= word;
`ifdef MEM_PARITY_EN
      err1_q   <= req & err;
`endif
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] data2_q;
    logic                  valid2_q;
`ifdef MEM_PARITY_EN
    logic                  err2_q;
`endif
    always_ff @(posedge clk) begin
      if (!rstn) begin
        data2_q  <= '0;
        valid2_q <= 1'b0;
`ifdef MEM_PARITY_EN
        err2_q   <= 1'b0;
`endif
      end else begin
        valid2_q <= valid1_q;
        if (valid1_q) data2_q <= data1_q;
`ifdef MEM_PARITY_EN
        err2_q   <= err1_q;
`endif
      end
    end
    assign data_out   = data2_q;
    assign rd_valid   = valid2_q;
`ifdef MEM_PARITY_EN
    assign parity_err = err2_q;
`endif
  end else begin : g_lat1
    assign data_out   = data1_q;
    assign rd_valid   = valid1_q;
`ifdef MEM_PARITY_EN
    assign parity_err = err1_q;
`endif
  end

endmodule

// File: rtl/mem_bank_mp.sv
// Multi-read-port, single-write-port memory bank with byte enables, write-first forwarding
// and a clear-on-reset sequencer. Define MEM_PARITY_EN for per-byte parity storage.
module mem_bank_mp
  import mem_bank_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned MEM_SIZE   = 64,
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned RD_LATENCY = 1
) (
  input logic          clk,
  input logic          rstn,
  mem_bank_mp_if.slave bus
);

  localparam int unsigned NB = DATA_WIDTH / BYTE_WIDTH;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  init_we;
  logic                  ready;

  logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE];
  logic                  wr_in_range;
  logic                  wr_fire;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic [DATA_WIDTH-1:0] wr_word;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    init_we = 1'b0;
    case (state_q)
      StInit: begin
        init_we = 1'b1;
        if (ptr_q == ADDR_WIDTH'(MEM_SIZE - 1)) begin
          state_d = StReady;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + ADDR_WIDTH'(1);
        end
      end
      StReady: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StInit;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign ready         = (state_q == StReady);
  assign bus.init_busy = ~ready;

  assign wr_in_range = {1'b0, bus.wr_address} < (ADDR_WIDTH+1)'(MEM_SIZE);
  assign wr_idx      = wr_in_range ? bus.wr_address : '0;
  assign wr_fire     = rstn && ready && bus.wr_en && wr_in_range;
  assign wr_word     = DATA_WIDTH'(byte_merge(MAX_DW'(mem_q[wr_idx]), MAX_DW'(bus.data_in),
                                              MAX_NB'(bus.wr_be)));

  // Array has no reset of its own; the sequencer zeroes it after rstn releases.
  always_ff @(posedge clk) begin
    if (rstn && init_we) begin
      mem_q[ptr_q] <= '0;
    end else if (wr_fire) begin
      mem_q[wr_idx] <= wr_word;
    end
  end

`ifdef MEM_PARITY_EN
  logic [NB-1:0] par_q [MEM_SIZE];
  logic [NB-1:0] wr_par;

  assign wr_par = NB'(byte_parity(MAX_DW'(bus.data_in))) ^ {NB{bus.wr_par_flip}};

  always_ff @(posedge clk) begin
    if (rstn && init_we) begin
      par_q[ptr_q] <= '0;
    end else if (wr_fire) begin
      par_q[wr_idx] <= (par_q[wr_idx] & ~bus.wr_be) | (wr_par & bus.wr_be);
    end
  end
`endif

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] idx;

    assign addr = bus.rd_address[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign idx  = ({1'b0, addr} < (ADDR_WIDTH+1)'(MEM_SIZE)) ? addr : '0;

    mem_rd_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .MEM_SIZE   (MEM_SIZE),
      .RD_LATENCY (RD_LATENCY)
    ) u_rd_port (
      .clk        (clk),
      .rstn       (rstn),
      .ready      (ready),
      .rd_en      (bus.rd_en[i]),
      .rd_address (addr),
      .mem_word   (mem_q[idx]),
      .wr_fire    (wr_fire),
      .wr_address (bus.wr_address),
      .wr_data    (bus.data_in),
      .wr_be      (bus.wr_be),
`ifdef MEM_PARITY_EN
      .mem_par    (par_q[idx]),
      .wr_par     (wr_par),
      .parity_err (bus.parity_err[i]),
`endif
      .data_out   (bus.data_out[i*DATA_WIDTH +: DATA_WIDTH]),
      .rd_valid   (bus.rd_valid[i])
    );
  end

endmodule

// File: tb/tb_mem_bank_mp.sv
// Randomized self-checking bench for mem_bank_mp against a word-array reference model.
module tb_mem_bank_mp;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 6;
  localparam int unsigned MS = 48;
  localparam int unsigned NR = 2;
  localparam int unsigned RL = 1;
  localparam int unsigned NB = DW / 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  mem_bank_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR)) bus ();

  mem_bank_mp #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .MEM_SIZE   (MS),
    .NUM_RD     (NR),
    .RD_LATENCY (RL)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct packed {
    logic [NR-1:0]    v;
    logic [NR-1:0]    pe;
    logic [NR*DW-1:0] d;
  } exp_t;

  exp_t             exp_q[$];
  logic [DW-1:0]    ref_mem [MS];
  logic [NB-1:0]    ref_bad [MS];
  logic [NR*DW-1:0] last_d = '0;
  int unsigned      init_cnt = 0;
  int               checks = 0;
  int               failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.wr_en      = 1'b0;
    bus.wr_address = '0;
    bus.wr_be      = '0;
    bus.data_in    = '0;
    bus.rd_en      = '0;
    bus.rd_address = '0;
`ifdef MEM_PARITY_EN
    bus.wr_par_flip = 1'b0;
`endif
  endtask

  task automatic set_wr(input int addr, input logic [DW-1:0] data, input logic [NB-1:0] be);
    bus.wr_en      = 1'b1;
    bus.wr_address = AW'(addr);
    bus.data_in    = data;
    bus.wr_be      = be;
  endtask

  task automatic set_rd(input int port, input int addr);
    bus.rd_en[port]                 = 1'b1;
    bus.rd_address[port*AW +: AW]   = AW'(addr);
  endtask

  task automatic rand_inputs();
    bus.wr_en      = 1'($urandom_range(0, 1));
    bus.wr_address = AW'($urandom_range(0, MS + 7));
    bus.wr_be      = NB'($urandom);
    bus.data_in    = $urandom;
`ifdef MEM_PARITY_EN
    bus.wr_par_flip = ($urandom_range(0, 7) == 0);
`endif
    for (int i = 0; i < NR; i++) begin
      bus.rd_en[i] = 1'($urandom_range(0, 1));
      bus.rd_address[i*AW +: AW] = ($urandom_range(0, 3) == 0) ? bus.wr_address
                                                                  : AW'($urandom_range(0, MS + 7));
    end
  endtask

  // Apply one clock of the current inputs to the model, then compare outputs after the edge.
  task automatic tick();
    exp_t e;
    bit   acc;
    bit   flip;
    int   a;
    e    = '0;
    acc  = rstn && (init_cnt >= MS);
    flip = 1'b0;
`ifdef MEM_PARITY_EN
    flip = bus.wr_par_flip;
`endif
    if (acc && bus.wr_en && int'(bus.wr_address) < MS) begin
      a = int'(bus.wr_address);
      for (int k = 0; k < NB; k++) begin
        if (bus.wr_be[k]) begin
          ref_mem[a][k*8 +: 8] = bus.data_in[k*8 +: 8];
          ref_bad[a][k]        = flip;
        end
      end
    end
    for (int i = 0; i < NR; i++) begin
      if (acc && bus.rd_en[i]) begin
        a      = int'(bus.rd_address[i*AW +: AW]);
        e.v[i] = 1'b1;
        if (a < MS) begin
          e.d[i*DW +: DW] = ref_mem[a];
          e.pe[i]         = |ref_bad[a];
        end
      end
    end
    if (!rstn) begin
      init_cnt = 0;
    end else if (init_cnt < MS) begin
      ref_mem[init_cnt] = '0;
      ref_bad[init_cnt] = '0;
      init_cnt++;
    end

    @(posedge clk);
    #1;
    if (!rstn) begin
      exp_q.delete();
      last_d = '0;
      e      = '0;
    end else begin
      exp_q.push_back(e);
      if (exp_q.size() == RL) e = exp_q.pop_front();
      else e = '0;
    end
    for (int i = 0; i < NR; i++) begin
      if (e.v[i]) last_d[i*DW +: DW] = e.d[i*DW +: DW];
    end

    check_eq("init_busy", 64'(bus.init_busy), 64'(init_cnt < MS));
    for (int i = 0; i < NR; i++) begin
      check_eq($sformatf("rd_valid[%0d]", i), 64'(bus.rd_valid[i]), 64'(e.v[i]));
      check_eq($sformatf("data_out[%0d]", i), 64'(bus.data_out[i*DW +: DW]),
               64'(last_d[i*DW +: DW]));
`ifdef MEM_PARITY_EN
      check_eq($sformatf("parity_err[%0d]", i), 64'(bus.parity_err[i]),
               64'(e.v[i] & e.pe[i]));
`endif
    end
  endtask

  // Directed single read with a literal expectation on top of the model checks.
  task automatic read_lit(input int port, input int addr, input logic [DW-1:0] exp,
                          input string tag);
    idle();
    set_rd(port, addr);
    tick();
    idle();
    repeat (RL - 1) tick();
    check_eq(tag, 64'(bus.data_out[port*DW +: DW]), 64'(exp));
    check_eq({tag, "_valid"}, 64'(bus.rd_valid[port]), 64'd1);
  endtask

  initial begin
    int busy_cnt;
    for (int k = 0; k < MS; k++) begin
      ref_mem[k] = '0;
      ref_bad[k] = '0;
    end
    idle();
    rstn = 1'b0;
    repeat (3) begin
      rand_inputs();
      tick();
    end

    // Clear sequence; traffic during it must be ignored.
    rstn = 1'b1;
    repeat (MS) begin
      rand_inputs();
      tick();
    end
    idle();
    read_lit(0, 0, '0, "init_word0");
    read_lit(1, 31, '0, "init_word31");
    read_lit(0, MS - 1, '0, "init_last_word");
    read_lit(1, 63, '0, "oor_word63");

    // Byte-enabled merge.
    idle();
    set_wr(1, 32'h11223344, 4'b1111);
    tick();
    idle();
    set_wr(1, 32'hAABBCCDD, 4'b0101);
    tick();
    read_lit(0, 1, 32'h11BB33DD, "be_merge");

    // Same-cycle write/read forwarding.
    idle();
    set_wr(5, 32'hA5A5A5A5, 4'b1111);
    set_rd(0, 5);
    set_rd(1, 6);
    tick();
    idle();
    repeat (RL - 1) tick();
    check_eq("fwd_port0", 64'(bus.data_out[DW-1:0]), 64'h00000000A5A5A5A5);
    check_eq("fwd_port1", 64'(bus.data_out[2*DW-1:DW]), 64'h0);
    check_eq("fwd_valid", 64'(bus.rd_valid), 64'h3);

    // Partial forwarding: only byte 3 comes from the write.
    idle();
    set_wr(1, 32'hEE000000, 4'b1000);
    set_rd(0, 1);
    set_rd(1, 1);
    tick();
    idle();
    repeat (RL - 1) tick();
    check_eq("fwd_partial0", 64'(bus.data_out[DW-1:0]), 64'h00000000EEBB33DD);
    check_eq("fwd_partial1", 64'(bus.data_out[2*DW-1:DW]), 64'h00000000EEBB33DD);

    // wr_be=0 leaves the word untouched.
    idle();
    set_wr(5, 32'h0, 4'b0000);
    tick();
    read_lit(0, 5, 32'hA5A5A5A5, "be_zero_noop");

    // Out-of-range write is dropped; read returns 0.
    idle();
    set_wr(50, 32'hDEADBEEF, 4'b1111);
    tick();
    read_lit(0, 50, '0, "oor_read");
    read_lit(1, 2, '0, "oor_no_alias2");
    read_lit(1, 18, '0, "oor_no_alias18");

    // Randomized traffic, including out-of-range and colliding addresses.
    repeat (500) begin
      rand_inputs();
      tick();
    end

    // Sweep every word through both ports.
    for (int a = 0; a < MS; a++) begin
      idle();
      set_rd(0, a);
      set_rd(1, MS - 1 - a);
      tick();
    end

    // Reset midway through a clear restarts it from word 0.
    idle();
    set_wr(2, 32'h12345678, 4'b1111);
    tick();
    read_lit(0, 2, 32'h12345678, "pre_reset_word2");
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    repeat (MS / 2) begin
      rand_inputs();
      tick();
    end
    rstn = 1'b0;
    tick();
    busy_cnt = int'(bus.init_busy);
    rstn = 1'b1;
    repeat (MS) begin
      rand_inputs();
      tick();
      busy_cnt += int'(bus.init_busy);
    end
    check_eq("restart_busy_cycles", 64'(busy_cnt), 64'(MS));
    read_lit(0, 2, '0, "restart_word2");

`ifdef MEM_PARITY_EN
    idle();
    set_wr(3, 32'h01020304, 4'b1111);
    bus.wr_par_flip = 1'b1;
    tick();
    read_lit(0, 3, 32'h01020304, "par_flip_data");
    check_eq("par_flip_err", 64'(bus.parity_err[0]), 64'd1);
    idle();
    set_wr(3, 32'h01020304, 4'b1111);
    tick();
    read_lit(1, 3, 32'h01020304, "par_clean_data");
    check_eq("par_clean_err", 64'(bus.parity_err[1]), 64'd0);
`endif

    idle();
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
